// File: rtl/net_config_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : net_config_ctrl
// Purpose  : Register-writable network identity (IP/gateway/subnet/MAC)
//            with an atomic pause/apply/announce commit to the stack.
//            Optional macro NET_CONFIG_GARP_EN enables the gratuitous-ARP
//            ANNOUNCE state.
// Revision : 1.0 - initial release
// ============================================================================
module net_config_ctrl #(
    parameter logic [31:0] C_IP            = 32'h0,
    parameter logic [31:0] C_GATEWAY       = 32'h0,
    parameter logic [31:0] C_SUBNET        = 32'h0,
    parameter logic [47:0] C_MAC           = 48'h0,
    parameter int unsigned C_PAUSE_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_wr_en,
    input  logic        cfg_rd_en,
    input  logic [2:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    output logic [31:0] cfg_rdata,
    output logic        cfg_busy,
    output logic        stack_pause,
    input  logic        stack_idle,
    output logic        garp_req,
    input  logic        garp_ack,
    output logic [31:0] ip,
    output logic [31:0] gateway,
    output logic [31:0] subnet,
    output logic [47:0] mac,
    output logic [47:0] mac_big
);

    localparam int unsigned CNT_W = (C_PAUSE_TIMEOUT > 1) ? $clog2(C_PAUSE_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(C_PAUSE_TIMEOUT - 1);
    localparam bit C_TIMEOUT_EN = (C_PAUSE_TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PAUSE    = 2'd1,
        ST_APPLY    = 2'd2,
        ST_ANNOUNCE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      sh_ip_q, sh_ip_d, sh_gw_q, sh_gw_d, sh_sn_q, sh_sn_d;
    logic [47:0]      sh_mac_q, sh_mac_d;
    logic [31:0]      act_ip_q, act_ip_d, act_gw_q, act_gw_d, act_sn_q, act_sn_d;
    logic [47:0]      act_mac_q, act_mac_d;
    logic [7:0]       version_q, version_d;
    logic             err_q, err_d;
    logic             pause_q, pause_d;
    logic             garp_q, garp_d;
    logic             busy_q, busy_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             w_commit;

`ifndef NET_CONFIG_GARP_EN
    logic unused_garp_ack;
    assign unused_garp_ack = garp_ack;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_ip_d   = sh_ip_q;
        sh_gw_d   = sh_gw_q;
        sh_sn_d   = sh_sn_q;
        sh_mac_d  = sh_mac_q;
        act_ip_d  = act_ip_q;
        act_gw_d  = act_gw_q;
        act_sn_d  = act_sn_q;
        act_mac_d = act_mac_q;
        version_d = version_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        w_commit  = 1'b0;

        // Reads see the pre-write register values of this cycle.
        if (cfg_rd_en) begin
            case (cfg_addr)
                3'd0:    rdata_d = sh_ip_q;
                3'd1:    rdata_d = sh_gw_q;
                3'd2:    rdata_d = sh_sn_q;
                3'd3:    rdata_d = sh_mac_q[31:0];
                3'd4:    rdata_d = {16'h0, sh_mac_q[47:32]};
                3'd6:    rdata_d = {16'h0, version_q, 6'h0, err_q, busy_q};
                default: rdata_d = 32'h0;
            endcase
        end

        if (cfg_wr_en) begin
            case (cfg_addr)
                3'd0: if (!busy_q) sh_ip_d = cfg_wdata;
                3'd1: if (!busy_q) sh_gw_d = cfg_wdata;
                3'd2: if (!busy_q) sh_sn_d = cfg_wdata;
                3'd3: if (!busy_q) sh_mac_d[31:0] = cfg_wdata;
                3'd4: if (!busy_q) sh_mac_d[47:32] = cfg_wdata[15:0];
                3'd5: begin
                    if (cfg_wdata[1]) err_d = 1'b0;
                    w_commit = cfg_wdata[0] & ~busy_q;
                end
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (w_commit) begin
                    state_d = ST_PAUSE;
                    cnt_d   = '0;
                end
            end
            ST_PAUSE: begin
                // A drained stack takes priority over an expiring timeout.
                if (stack_idle) begin
                    state_d = ST_APPLY;
                end else if (C_TIMEOUT_EN && (cnt_q == C_CNT_LAST)) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_APPLY: begin
                act_ip_d  = sh_ip_q;
                act_gw_d  = sh_gw_q;
                act_sn_d  = sh_sn_q;
                act_mac_d = sh_mac_q;
                version_d = version_q + 8'd1;
`ifdef NET_CONFIG_GARP_EN
                state_d   = ST_ANNOUNCE;
`else
                state_d   = ST_IDLE;
`endif
            end
`ifdef NET_CONFIG_GARP_EN
            ST_ANNOUNCE: begin
                if (garp_ack) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        pause_d = (state_d == ST_PAUSE) || (state_d == ST_APPLY);
        busy_d  = (state_d != ST_IDLE);
`ifdef NET_CONFIG_GARP_EN
        garp_d  = (state_d == ST_ANNOUNCE);
`else
        garp_d  = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sh_ip_q   <= C_IP;
            sh_gw_q   <= C_GATEWAY;
            sh_sn_q   <= C_SUBNET;
            sh_mac_q  <= C_MAC;
            act_ip_q  <= C_IP;
            act_gw_q  <= C_GATEWAY;
            act_sn_q  <= C_SUBNET;
            act_mac_q <= C_MAC;
            version_q <= 8'h0;
            err_q     <= 1'b0;
            pause_q   <= 1'b0;
            garp_q    <= 1'b0;
            busy_q    <= 1'b0;
            rdata_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_ip_q   <= sh_ip_d;
            sh_gw_q   <= sh_gw_d;
            sh_sn_q   <= sh_sn_d;
            sh_mac_q  <= sh_mac_d;
            act_ip_q  <= act_ip_d;
            act_gw_q  <= act_gw_d;
            act_sn_q  <= act_sn_d;
            act_mac_q <= act_mac_d;
            version_q <= version_d;
            err_q     <= err_d;
            pause_q   <= pause_d;
            garp_q    <= garp_d;
            busy_q    <= busy_d;
            rdata_q   <= rdata_d;
        end
    end

    assign cfg_rdata   = rdata_q;
    assign cfg_busy    = busy_q;
    assign stack_pause = pause_q;
    assign garp_req    = garp_q;
    assign ip          = {act_ip_q[7:0], act_ip_q[15:8], act_ip_q[23:16], act_ip_q[31:24]};
    assign gateway     = {act_gw_q[7:0], act_gw_q[15:8], act_gw_q[23:16], act_gw_q[31:24]};
    assign subnet      = {act_sn_q[7:0], act_sn_q[15:8], act_sn_q[23:16], act_sn_q[31:24]};
    assign mac         = {act_mac_q[7:0], act_mac_q[15:8], act_mac_q[23:16],
                          act_mac_q[31:24], act_mac_q[39:32], act_mac_q[47:40]};
    assign mac_big     = act_mac_q;

endmodule
`default_nettype wire

// File: tb/tb_net_config_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_net_config_ctrl
// Purpose  : Self-checking bench for net_config_ctrl (register table,
//            directed commit/timeout/reset sequences, randomized commits).
// Revision : 1.0 - initial release
// ============================================================================
module tb_net_config_ctrl;

    localparam logic [31:0] TB_IP  = 32'hC0A80164;
    localparam logic [31:0] TB_GW  = 32'hC0A80101;
    localparam logic [31:0] TB_SN  = 32'hFFFFFF00;
    localparam logic [47:0] TB_MAC = 48'h02005E102030;
    localparam int          TB_TO  = 16;
`ifdef NET_CONFIG_GARP_EN
    localparam bit GARP = 1'b1;
`else
    localparam bit GARP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_wr_en, cfg_rd_en, stack_idle, garp_ack;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_wdata, cfg_rdata, ip, gateway, subnet;
    logic        cfg_busy, stack_pause, garp_req;
    logic [47:0] mac, mac_big;

    int checks = 0;
    int errors = 0;

    // Reference model: shadow words as seen on the bus, active set big-endian.
    logic [31:0] sh [5];
    logic [31:0] m_ip, m_gw, m_sn;
    logic [47:0] m_mac;
    logic [7:0]  m_ver;
    logic        m_err;

    net_config_ctrl #(
        .C_IP(TB_IP), .C_GATEWAY(TB_GW), .C_SUBNET(TB_SN), .C_MAC(TB_MAC),
        .C_PAUSE_TIMEOUT(TB_TO)
    ) dut (
        .clk(clk), .rst(rst), .cfg_wr_en(cfg_wr_en), .cfg_rd_en(cfg_rd_en),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .cfg_busy(cfg_busy), .stack_pause(stack_pause), .stack_idle(stack_idle),
        .garp_req(garp_req), .garp_ack(garp_ack), .ip(ip), .gateway(gateway),
        .subnet(subnet), .mac(mac), .mac_big(mac_big)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] swap32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = x[8*(3-i) +: 8];
        return r;
    endfunction

    function automatic logic [47:0] swap48(input logic [47:0] x);
        logic [47:0] r;
        for (int i = 0; i < 6; i++) r[8*i +: 8] = x[8*(5-i) +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cfg_wr_en = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_wr_en = 1'b0;
    endtask

    task automatic rd(input string name, input logic [2:0] a, input logic [31:0] exp);
        cfg_rd_en = 1'b1; cfg_addr = a;
        tick();
        cfg_rd_en = 1'b0;
        check(name, cfg_rdata, exp);
    endtask

    task automatic model_reset();
        sh[0] = TB_IP; sh[1] = TB_GW; sh[2] = TB_SN;
        sh[3] = TB_MAC[31:0]; sh[4] = {16'h0, TB_MAC[47:32]};
        m_ip = TB_IP; m_gw = TB_GW; m_sn = TB_SN; m_mac = TB_MAC;
        m_ver = 8'h0; m_err = 1'b0;
    endtask

    task automatic model_wr(input logic [2:0] a, input logic [31:0] d);
        if (a == 3'd4)     sh[4] = {16'h0, d[15:0]};
        else if (a < 3'd4) sh[a] = d;
        else if (a == 3'd5 && d[1]) m_err = 1'b0;
    endtask

    function automatic logic [31:0] model_rd(input logic [2:0] a);
        if (a <= 3'd4) return sh[a];
        if (a == 3'd6) return {16'h0, m_ver, 6'h0, m_err, 1'b0};
        return 32'h0;
    endfunction

    task automatic model_apply();
        m_ip = sh[0]; m_gw = sh[1]; m_sn = sh[2];
        m_mac = {sh[4][15:0], sh[3]};
        m_ver = m_ver + 8'd1;
    endtask

    task automatic check_out(input string tag, input logic [31:0] eip, input logic [31:0] egw,
                             input logic [31:0] esn, input logic [47:0] emac);
        check({tag, "_ip"}, ip, swap32(eip));
        check({tag, "_gw"}, gateway, swap32(egw));
        check({tag, "_sn"}, subnet, swap32(esn));
        check({tag, "_mac"}, mac, swap48(emac));
        check({tag, "_macbig"}, mac_big, emac);
    endtask

    // Commit with stack_idle raised d cycles into PAUSE and garp_ack raised
    // ad cycles after garp_req appears; tracks pause/garp durations.
    task automatic do_commit(input logic [31:0] ctl, input int d, input int ad);
        logic [31:0] oip, ogw, osn, nip, ngw, nsn;
        logic [47:0] omac, nmac;
        bit ok;
        int pcnt, gcnt;
        ok = (d <= TB_TO - 1);
        if (ctl[1]) m_err = 1'b0;
        oip = m_ip; ogw = m_gw; osn = m_sn; omac = m_mac;
        nip = ok ? sh[0] : m_ip;
        ngw = ok ? sh[1] : m_gw;
        nsn = ok ? sh[2] : m_sn;
        nmac = ok ? {sh[4][15:0], sh[3]} : m_mac;
        stack_idle = 1'b0; garp_ack = 1'b0;
        wr(3'd5, ctl);
        pcnt = 0; gcnt = 0;
        for (int k = 0; k < 80; k++) begin
            if (stack_pause) pcnt++;
            if (garp_req) gcnt++;
            if (stack_pause) check_out("hold", oip, ogw, osn, omac);
            else             check_out("new", nip, ngw, nsn, nmac);
            if (!cfg_busy) break;
            stack_idle = (k >= d);
            garp_ack = (gcnt > ad);
            tick();
        end
        check("commit_done_busy", cfg_busy, 1'b0);
        check("pause_cycles", pcnt, ok ? d + 2 : TB_TO);
        check("garp_cycles", gcnt, (GARP && ok) ? ad + 1 : 0);
        stack_idle = 1'b0; garp_ack = 1'b0;
        if (ok) model_apply();
        else    m_err = 1'b1;
        rd("status_after_commit", 3'd6, model_rd(3'd6));
    endtask

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [8];

    initial begin
        vt[0] = '{3'd0, 32'hC0A80199, 32'hC0A80199};
        vt[1] = '{3'd1, 32'h0A0000FE, 32'h0A0000FE};
        vt[2] = '{3'd2, 32'hFF000000, 32'hFF000000};
        vt[3] = '{3'd3, 32'h11223344, 32'h11223344};
        vt[4] = '{3'd4, 32'hABCD5566, 32'h00005566};
        vt[5] = '{3'd5, 32'hFFFFFFFC, 32'h00000000};
        vt[6] = '{3'd6, 32'hFFFFFFFF, 32'h00000000};
        vt[7] = '{3'd7, 32'h12345678, 32'h00000000};

        rst = 1'b1; cfg_wr_en = 1'b0; cfg_rd_en = 1'b0; cfg_addr = 3'd0;
        cfg_wdata = 32'h0; stack_idle = 1'b0; garp_ack = 1'b0;
        model_reset();
        tick(); tick();
        rst = 1'b0;
        tick();

        check("rst_ip", ip, 32'h6401A8C0);
        check("rst_mac_big", mac_big, TB_MAC);
        check("rst_pause", stack_pause, 1'b0);
        check("rst_busy", cfg_busy, 1'b0);
        check("rst_garp", garp_req, 1'b0);
        check("rst_rdata", cfg_rdata, 32'h0);
        rd("rst_status", 3'd6, 32'h0);

        for (int i = 0; i < 8; i++) begin
            wr(vt[i].addr, vt[i].wdata);
            model_wr(vt[i].addr, vt[i].wdata);
            rd($sformatf("table_rd_%0d", i), vt[i].addr, vt[i].exp);
        end

        // Simultaneous read and write returns the pre-write value.
        cfg_wr_en = 1'b1; cfg_rd_en = 1'b1; cfg_addr = 3'd0; cfg_wdata = 32'h0A000001;
        tick();
        cfg_wr_en = 1'b0; cfg_rd_en = 1'b0;
        check("rdwr_old", cfg_rdata, 32'hC0A80199);
        model_wr(3'd0, 32'h0A000001);
        rd("rdwr_new", 3'd0, 32'h0A000001);

        do_commit(32'h1, 0, 0);
        check("first_commit_ip", ip, 32'h0100000A);
        rd("first_commit_status", 3'd6, 32'h00000100);

        do_commit(32'h1, 16, 0);
        rd("timeout_status_err", 3'd6, {16'h0, m_ver, 6'h0, 1'b1, 1'b0});
        wr(3'd5, 32'h2); model_wr(3'd5, 32'h2);
        rd("err_cleared", 3'd6, model_rd(3'd6));
        do_commit(32'h1, 15, 1);

        // Writes and a second commit during PAUSE must be ignored.
        stack_idle = 1'b0;
        wr(3'd5, 32'h1);
        wr(3'd3, 32'hDEADBEEF);
        wr(3'd5, 32'h1);
        rd("busy_wr_readback", 3'd3, sh[3]);
        check("busy_during_pause", cfg_busy, 1'b1);
        stack_idle = 1'b1; garp_ack = 1'b1;
        for (int k = 0; k < 20 && cfg_busy; k++) tick();
        stack_idle = 1'b0; garp_ack = 1'b0;
        tick();
        check("busy_wr_done", cfg_busy, 1'b0);
        model_apply();
        check_out("busy_wr_apply", m_ip, m_gw, m_sn, m_mac);
        rd("busy_wr_status", 3'd6, model_rd(3'd6));

        for (int it = 0; it < 320; it++) begin
            int n, d, ad;
            logic [2:0] a;
            logic [31:0] v;
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) begin
                a = 3'($urandom_range(0, 4));
                v = $urandom;
                wr(a, v);
                model_wr(a, v);
            end
            a = 3'($urandom_range(0, 7));
            rd("rand_rd", a, model_rd(a));
            d = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 18) : $urandom_range(0, 4);
            ad = $urandom_range(0, 2);
            do_commit(($urandom_range(0, 3) == 0) ? 32'h3 : 32'h1, d, ad);
        end

        // Reset in the middle of a commit.
        stack_idle = GARP; garp_ack = 1'b0;
        wr(3'd0, 32'h01020304);
        wr(3'd5, 32'h1);
        if (GARP) begin
            for (int k = 0; k < 20 && !garp_req; k++) tick();
            check("garp_before_reset", garp_req, 1'b1);
        end
        #2 rst = 1'b1;
        #1;
        check("midrst_garp", garp_req, 1'b0);
        check("midrst_pause", stack_pause, 1'b0);
        check("midrst_busy", cfg_busy, 1'b0);
        check("midrst_rdata", cfg_rdata, 32'h0);
        model_reset();
        check_out("midrst", m_ip, m_gw, m_sn, m_mac);
        stack_idle = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        rd("midrst_shadow", 3'd0, TB_IP);
        rd("midrst_status", 3'd6, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
